// File: rtl/apb_mig_pkg.sv
// Shared types for the APB/MIG read-path checker: error kind codes,
// APB phase tracking states and the number of error kinds.
package apb_mig_pkg;

  localparam int NUM_KINDS = 6;

  // Kind code doubles as the bit index into the sticky error vector.
  typedef enum logic [2:0] {
    ERR_RD_OUTSIDE_READ = 3'd0,
    ERR_PUSH_WHEN_FULL  = 3'd1,
    ERR_OCC_OVERFLOW    = 3'd2,
    ERR_OCC_UNDERFLOW   = 3'd3,
    ERR_ACCESS_TIMEOUT  = 3'd4,
    ERR_APB_PROTOCOL    = 3'd5
  } err_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_mig_occ_cnt.sv
// Per-channel FIFO occupancy tracker. Counts pushes and pops seen on the
// channel and flags a push-only into a full FIFO or a pop-only from an empty
// one; the count is held on either violation.
module apb_mig_occ_cnt #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  logic i_pop,
  output logic o_ovf,
  output logic o_unf
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [OCC_W-1:0] r_occ;
  logic             w_push_only;
  logic             w_pop_only;

  assign w_push_only = i_push & ~i_pop;
  assign w_pop_only  = i_pop & ~i_push;
  assign o_ovf       = w_push_only && (r_occ == OCC_W'(FIFO_DEPTH));
  assign o_unf       = w_pop_only && (r_occ == '0);

  // Occupancy update; simultaneous push and pop leave it unchanged
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_occ <= '0;
    end else if (w_push_only && !o_ovf) begin
      r_occ <= r_occ + 1'b1;
    end else if (w_pop_only && !o_unf) begin
      r_occ <= r_occ - 1'b1;
    end
  end

endmodule

// File: rtl/apb_mig_checker.sv
// Passive checker for MIG-to-APB read channels. Tracks the APB slave phase,
// per-channel FIFO occupancy and ACCESS wait length, and records errors as
// sticky flags, a saturating error-cycle count and a first-error capture.
// Optional: define APB_MIG_CHECKER_SVA_EN to compile concurrent assertions
// that report each error kind as it is detected.
//
// state  | meaning
// IDLE   | no transfer in progress
// SETUP  | psel seen without penable, expecting penable next
// ACCESS | transfer in access phase, waiting for pready
module apb_mig_checker
  import apb_mig_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 16,
  parameter int ERR_CNT_W  = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 pclk_i,
  input  logic                 preset_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic                 pready_i,
  input  logic [NUM_CH-1:0]    mig_valid_i,
  input  logic [NUM_CH-1:0]    fifo_pop_i,
  input  logic [NUM_CH-1:0]    fifo_w_full_i,
  input  logic [NUM_CH-1:0]    fifo_r_empty_i,
  input  logic                 clr_i,
  output logic [5:0]           err_sticky_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 first_err_vld_o,
  output logic [2:0]           first_err_kind_o,
  output logic [CH_W-1:0]      first_err_ch_o,
  output logic                 irq_o
);

  localparam int TO_MAX = (TIMEOUT > 0) ? TIMEOUT : 1;
  localparam int TO_W   = $clog2(TO_MAX + 1);

  apb_state_e                         r_state;
  apb_state_e                         w_state_nxt;
  logic                               w_proto_err;
  logic                               r_psel_q;
  logic                               r_pwrite_q;
  logic [TO_W-1:0]                    r_to_cnt;
  logic                               w_to_hit;
  logic [NUM_CH-1:0]                  w_ovf;
  logic [NUM_CH-1:0]                  w_unf;
  logic [NUM_KINDS-1:0][NUM_CH-1:0]   w_err_kc;
  logic [NUM_KINDS-1:0]               w_err_kind;
  logic                               w_any;
  logic                               w_found;
  logic [2:0]                         w_first_kind;
  logic [CH_W-1:0]                    w_first_ch;
  logic [5:0]                         w_sticky_nxt;
  logic [5:0]                         r_sticky;
  logic [ERR_CNT_W-1:0]               r_cnt;
  logic                               r_fvld;
  logic [2:0]                         r_fkind;
  logic [CH_W-1:0]                    r_fch;
  logic                               r_irq;

  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_occ
    apb_mig_occ_cnt #(.FIFO_DEPTH(FIFO_DEPTH)) u_occ (
      .i_clk  (pclk_i),
      .i_rst  (preset_i),
      .i_push (mig_valid_i[g]),
      .i_pop  (fifo_pop_i[g]),
      .o_ovf  (w_ovf[g]),
      .o_unf  (w_unf[g])
    );
  end

  // APB phase register plus previous-cycle psel/pwrite for stability checks
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      r_state    <= ST_IDLE;
      r_psel_q   <= 1'b0;
      r_pwrite_q <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_psel_q   <= psel_i;
      r_pwrite_q <= pwrite_i;
    end
  end

  // APB next phase; any protocol violation drops tracking back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_proto_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (penable_i) begin
          w_proto_err = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (psel_i) begin
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (psel_i && penable_i) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_proto_err = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (pready_i) begin
          w_state_nxt = psel_i ? ST_SETUP : ST_IDLE;
        end else if ((psel_i != r_psel_q) || (pwrite_i != r_pwrite_q)) begin
          w_proto_err = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The counter saturates at TIMEOUT so the hit fires only once per transfer
  assign w_to_hit = (TIMEOUT > 0) && (r_state == ST_ACCESS) && !pready_i &&
                    (r_to_cnt == TO_W'(TO_MAX - 1));

  // ACCESS wait counter, cleared whenever the next phase is not ACCESS
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      r_to_cnt <= '0;
    end else if (w_state_nxt != ST_ACCESS) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_ACCESS) && !pready_i && (r_to_cnt != TO_W'(TO_MAX))) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Gather this cycle's errors by kind and channel
  always_comb begin
    w_err_kc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_err_kc[ERR_RD_OUTSIDE_READ][c] = !fifo_r_empty_i[c] &&
                                         !((r_state == ST_ACCESS) && !pwrite_i);
      w_err_kc[ERR_PUSH_WHEN_FULL][c]  = mig_valid_i[c] & fifo_w_full_i[c];
      w_err_kc[ERR_OCC_OVERFLOW][c]    = w_ovf[c];
      w_err_kc[ERR_OCC_UNDERFLOW][c]   = w_unf[c];
    end
    w_err_kc[ERR_ACCESS_TIMEOUT][0] = w_to_hit;
    w_err_kc[ERR_APB_PROTOCOL][0]   = w_proto_err;
  end

  // Per-kind summary and lowest-kind-then-lowest-channel selection
  always_comb begin
    w_err_kind   = '0;
    w_found      = 1'b0;
    w_first_kind = '0;
    w_first_ch   = '0;
    for (int k = 0; k < NUM_KINDS; k++) begin
      w_err_kind[k] = |w_err_kc[k];
      for (int c = 0; c < NUM_CH; c++) begin
        if (!w_found && w_err_kc[k][c]) begin
          w_found      = 1'b1;
          w_first_kind = 3'(k);
          w_first_ch   = CH_W'(c);
        end
      end
    end
  end

  assign w_any        = |w_err_kind;
  assign w_sticky_nxt = (clr_i ? 6'd0 : r_sticky) | w_err_kind;

  // Error record; clr_i wipes history but keeps errors of its own cycle
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      r_sticky <= '0;
      r_cnt    <= '0;
      r_fvld   <= 1'b0;
      r_fkind  <= '0;
      r_fch    <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_sticky <= w_sticky_nxt;
      r_irq    <= |w_sticky_nxt;
      if (clr_i) begin
        r_cnt <= w_any ? ERR_CNT_W'(1) : '0;
      end else if (w_any && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (clr_i || !r_fvld) begin
        r_fvld  <= w_any;
        r_fkind <= w_first_kind;
        r_fch   <= w_first_ch;
      end
    end
  end

  assign err_sticky_o     = r_sticky;
  assign err_cnt_o        = r_cnt;
  assign first_err_vld_o  = r_fvld;
  assign first_err_kind_o = r_fkind;
  assign first_err_ch_o   = r_fch;
  assign irq_o            = r_irq;

`ifdef APB_MIG_CHECKER_SVA_EN
  genvar gk;
  for (gk = 0; gk < NUM_KINDS; gk++) begin : g_sva
    a_no_err: assert property (@(posedge pclk_i) disable iff (preset_i) !w_err_kind[gk])
      else $error("apb_mig_checker: error kind %0d detected", gk);
  end
`endif

endmodule

// File: tb/tb_apb_mig_checker.sv
// Bench for apb_mig_checker: directed scenarios with literal expectations,
// then randomized APB/FIFO traffic, all compared every cycle against a
// behavioural model of the error rules.
module tb_apb_mig_checker;

  localparam int NUM_CH     = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 16;
  localparam int ERR_CNT_W  = 8;
  localparam int CNT_MAX    = (1 << ERR_CNT_W) - 1;

  logic              pclk = 1'b0;
  logic              preset = 1'b1;
  logic              psel, pen, pwr, rdy, clr;
  logic [NUM_CH-1:0] valid, pop, full, empty;
  logic [5:0]        err_sticky;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic              fvld;
  logic [2:0]        fkind;
  logic [0:0]        fch;
  logic              irq;

  always #5 pclk = ~pclk;

  apb_mig_checker #(
    .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .pclk_i           (pclk),
    .preset_i         (preset),
    .psel_i           (psel),
    .penable_i        (pen),
    .pwrite_i         (pwr),
    .pready_i         (rdy),
    .mig_valid_i      (valid),
    .fifo_pop_i       (pop),
    .fifo_w_full_i    (full),
    .fifo_r_empty_i   (empty),
    .clr_i            (clr),
    .err_sticky_o     (err_sticky),
    .err_cnt_o        (err_cnt),
    .first_err_vld_o  (fvld),
    .first_err_kind_o (fkind),
    .first_err_ch_o   (fch),
    .irq_o            (irq)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model: bus phase 0 idle, 1 setup, 2 access
  int   m_phase;
  int   m_waits;
  int   m_occ [NUM_CH];
  bit   m_prev_psel, m_prev_pwr;
  bit [5:0] m_sticky;
  int   m_cnt;
  bit   m_fvld;
  int   m_fkind, m_fch;
  bit   m_irq;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_waits = 0;
    for (int c = 0; c < NUM_CH; c++) m_occ[c] = 0;
    m_prev_psel = 0; m_prev_pwr = 0;
    m_sticky = '0; m_cnt = 0; m_fvld = 0; m_fkind = 0; m_fch = 0; m_irq = 0;
  endtask

  task automatic model_step();
    bit ek [6][NUM_CH];
    int nph;
    bit any, found;
    if (preset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 6; k++)
      for (int c = 0; c < NUM_CH; c++) ek[k][c] = 0;
    nph = m_phase;
    if (m_phase == 0) begin
      if (pen) ek[5][0] = 1;
      nph = (!pen && psel) ? 1 : 0;
    end else if (m_phase == 1) begin
      if (psel && pen) nph = 2;
      else begin ek[5][0] = 1; nph = 0; end
    end else begin
      if (rdy) nph = psel ? 1 : 0;
      else if (psel != m_prev_psel || pwr != m_prev_pwr) begin ek[5][0] = 1; nph = 0; end
    end
    if (m_phase == 2 && !rdy) begin
      m_waits++;
      if (TIMEOUT > 0 && m_waits == TIMEOUT) ek[4][0] = 1;
    end
    if (nph != 2) m_waits = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!empty[c] && !(m_phase == 2 && !pwr)) ek[0][c] = 1;
      if (valid[c] && full[c]) ek[1][c] = 1;
      if (valid[c] && !pop[c]) begin
        if (m_occ[c] == FIFO_DEPTH) ek[2][c] = 1; else m_occ[c]++;
      end else if (pop[c] && !valid[c]) begin
        if (m_occ[c] == 0) ek[3][c] = 1; else m_occ[c]--;
      end
    end
    if (clr) begin
      m_sticky = '0; m_cnt = 0; m_fvld = 0; m_fkind = 0; m_fch = 0;
    end
    any = 0; found = 0;
    for (int k = 0; k < 6; k++)
      for (int c = 0; c < NUM_CH; c++)
        if (ek[k][c]) begin
          any = 1;
          m_sticky[k] = 1'b1;
          if (!found && !m_fvld) begin found = 1; m_fkind = k; m_fch = c; end
        end
    if (any) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      m_fvld = 1;
    end
    m_irq = |m_sticky;
    m_phase = nph;
    m_prev_psel = psel;
    m_prev_pwr = pwr;
  endtask

  task automatic step();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
  endtask

  task automatic idle_bus();
    psel = 0; pen = 0; pwr = 0; rdy = 0; clr = 0;
    valid = '0; pop = '0; full = '0; empty = '1;
  endtask

  task automatic do_reset();
    chk_en = 0;
    preset = 1;
    model_reset();
    step(); step();
    idle_bus();
    step();
    preset = 0;
    step();
    chk_en = 1;
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge pclk) begin
    if (chk_en) begin
      chk("sticky", int'(err_sticky), int'(m_sticky));
      chk("err_cnt", int'(err_cnt), m_cnt);
      chk("first_vld", int'(fvld), int'(m_fvld));
      chk("first_kind", int'(fkind), m_fkind);
      chk("first_ch", int'(fch), m_fch);
      chk("irq", int'(irq), int'(m_irq));
    end
  end

  task automatic rand_cycle(input bit stall);
    int r;
    r = $urandom_range(99);
    case (m_phase)
      0: begin
        rdy = $urandom_range(1);
        if (r < 3) begin pen = 1; psel = 1'($urandom_range(1)); end
        else if (r < 50) begin psel = 1; pen = 0; pwr = 1'($urandom_range(1)); end
        else begin psel = 0; pen = 0; end
      end
      1: begin
        psel = 1;
        pen = (r < 4) ? 1'b0 : 1'b1;
      end
      default: begin
        pen = 1;
        rdy = (r < (stall ? 2 : 35));
        if (rdy) psel = 1'($urandom_range(1));
        else begin
          psel = 1;
          if (r >= 98) pwr = ~pwr;
          else if (r == 97) psel = 0;
        end
      end
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_phase == 2 && !pwr) empty[c] = 1'($urandom_range(1));
      else empty[c] = ($urandom_range(99) < 3) ? 1'b0 : 1'b1;
      valid[c] = ($urandom_range(99) < 30);
      pop[c]   = ($urandom_range(99) < 30);
      full[c]  = ($urandom_range(99) < 5);
    end
    clr = ($urandom_range(199) == 0);
  endtask

  initial begin
    idle_bus();
    model_reset();
    do_reset();
    chk("rst_sticky", int'(err_sticky), 0);
    chk("rst_cnt", int'(err_cnt), 0);
    chk("rst_vld", int'(fvld), 0);
    chk("rst_irq", int'(irq), 0);

    // clean read transfer, three wait cycles, FIFO non-empty during ACCESS
    psel = 1; pen = 0; pwr = 0; step();
    pen = 1; step();
    empty[0] = 0; rdy = 0;
    repeat (3) step();
    rdy = 1; psel = 0; step();
    idle_bus(); step();
    chk("read_ok_sticky", int'(err_sticky), 0);
    chk("read_ok_cnt", int'(err_cnt), 0);

    // non-empty channel 1 while idle
    empty[1] = 0; step();
    idle_bus();
    chk("rdout_sticky", int'(err_sticky), 1);
    chk("rdout_kind", int'(fkind), 0);
    chk("rdout_ch", int'(fch), 1);
    chk("rdout_irq", int'(irq), 1);
    step();

    // clear in the same cycle as penable in IDLE
    pen = 1; clr = 1; step();
    idle_bus();
    chk("clr_sticky", int'(err_sticky), 32);
    chk("clr_kind", int'(fkind), 5);
    chk("clr_cnt", int'(err_cnt), 1);
    step();

    // occupancy overflow then underflow on channel 0
    do_reset();
    valid[0] = 1;
    repeat (8) step();
    chk("occ8_sticky", int'(err_sticky), 0);
    step();
    chk("ovf_sticky", int'(err_sticky), 4);
    idle_bus(); pop[0] = 1;
    repeat (8) step();
    chk("pop8_sticky", int'(err_sticky), 4);
    step();
    chk("unf_sticky", int'(err_sticky), 12);
    chk("unf_cnt", int'(err_cnt), 2);
    idle_bus(); step();

    // access timeout, pready low for 20 cycles
    do_reset();
    psel = 1; pwr = 1; step();
    pen = 1; step();
    rdy = 0;
    repeat (20) step();
    chk("to_sticky", int'(err_sticky), 16);
    rdy = 1; psel = 0; step();
    idle_bus(); step();
    chk("to_cnt", int'(err_cnt), 1);

    // simultaneous errors, then counter saturation
    do_reset();
    valid[1] = 1; full[1] = 1; empty[0] = 0; step();
    idle_bus();
    chk("multi_kind", int'(fkind), 0);
    chk("multi_ch", int'(fch), 0);
    chk("multi_cnt", int'(err_cnt), 1);
    chk("multi_sticky", int'(err_sticky), 3);
    empty[0] = 0;
    repeat (300) step();
    idle_bus();
    chk("sat_cnt", int'(err_cnt), 255);
    step();

    // reset asserted mid-transfer, released with the bus idle
    do_reset();
    psel = 1; pwr = 0; step();
    pen = 1; step();
    rdy = 0; step();
    do_reset();
    repeat (3) step();
    chk("midrst_sticky", int'(err_sticky), 0);
    chk("midrst_cnt", int'(err_cnt), 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rand_cycle(((i / 250) % 2) == 1);
      step();
    end
    idle_bus();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
